// File: rtl/pump_cmd_decoder_pkg.sv
// Shared types and constants for the pump front-panel command stage.
package pump_pkg;

  localparam int unsigned FRAG_COUNT = 3;

  localparam logic [1:0] TMR_30M  = 2'd0;
  localparam logic [1:0] TMR_60M  = 2'd1;
  localparam logic [1:0] TMR_120M = 2'd2;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_ON,
    CMD_OFF,
    CMD_MANUAL
  } cmd_t;

  function automatic int unsigned ms_to_cycles(int unsigned clk_hz, int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/pump_cmd_decoder_if.sv
// Front-panel buttons in, pump controller commands and status out.
interface pump_cmd_decoder_if;
  import pump_pkg::*;

  logic       btn_frag;
  logic       btn_timer;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_manual;
  logic [1:0] fragrance_select;
  logic [1:0] timer_select;
  logic       pump_on;
  logic       pump_off;
  logic       manual_on;
  logic [2:0] armed_mask;

  modport master (
    output btn_frag, btn_timer, btn_start, btn_stop, btn_manual,
    input  fragrance_select, timer_select, pump_on, pump_off, manual_on, armed_mask
  );

  modport slave (
    input  btn_frag, btn_timer, btn_start, btn_stop, btn_manual,
    output fragrance_select, timer_select, pump_on, pump_off, manual_on, armed_mask
  );
endinterface

// File: rtl/pump_cmd_decoder_btn_debounce.sv
// One button path: 2-FF synchroniser, stable-time debouncer, registered
// single-cycle press/release pulses.
module btn_debounce
  import pump_pkg::*;
#(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser, debounce counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  // Count while the synchronised level differs from the debounced one; any
  // return to the debounced level clears the count.
  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_d     = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(CYCLES)) begin
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/pump_cmd_decoder.sv
// Pump front-panel command decoder: debounced buttons, select cycling,
// arbitrated one-cycle command pulses and armed_mask status.
// Define LONG_PRESS_EN to enable the start-button long-press FSM.
module pump_cmd_decoder
  import pump_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 1_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input logic               clk,
  input logic               rst_n,
  pump_cmd_decoder_if.slave bus
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);
  localparam logic [1:0]  FRAG_LAST = 2'(FRAG_COUNT - 1);

  logic frag_press, timer_press, start_press, stop_press, manual_press;
  logic frag_rel, timer_rel, start_rel, stop_rel, manual_rel;
  logic start_on, start_man;

  btn_debounce #(.CYCLES(DB_CYCLES)) u_db_frag (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_frag), .press_o(frag_press), .release_o(frag_rel));
  btn_debounce #(.CYCLES(DB_CYCLES)) u_db_timer (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_timer), .press_o(timer_press), .release_o(timer_rel));
  btn_debounce #(.CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_start), .press_o(start_press), .release_o(start_rel));
  btn_debounce #(.CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_stop), .press_o(stop_press), .release_o(stop_rel));
  btn_debounce #(.CYCLES(DB_CYCLES)) u_db_manual (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_manual), .press_o(manual_press), .release_o(manual_rel));

`ifdef LONG_PRESS_EN
  localparam int unsigned LP_CYCLES = ms_to_cycles(CLOCK_FREQ, LONG_PRESS_MS);
  localparam int unsigned LW        = $clog2(LP_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} start_st_t;

  start_st_t     st_q, st_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          unused_rel;

  assign unused_rel = ^{frag_rel, timer_rel, stop_rel, manual_rel};

  // Start-button FSM state and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      hold_q <= '0;
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
    end
  end

  // Short press releases as pump_on; reaching the long-press time fires manual once.
  always_comb begin
    st_d      = st_q;
    hold_d    = hold_q;
    start_on  = 1'b0;
    start_man = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start_press) begin
          st_d   = ST_HELD;
          hold_d = '0;
        end
      end
      ST_HELD: begin
        if (start_rel) begin
          start_on = 1'b1;
          st_d     = ST_IDLE;
        end else if (hold_q == LW'(LP_CYCLES - 1)) begin
          start_man = 1'b1;
          st_d      = ST_LONG;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (start_rel) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end
`else
  localparam int unsigned unused_lp_cycles = ms_to_cycles(CLOCK_FREQ, LONG_PRESS_MS);

  logic unused_rel;

  assign unused_rel = ^{frag_rel, timer_rel, start_rel, stop_rel, manual_rel};
  assign start_on   = start_press;
  assign start_man  = 1'b0;
`endif

  cmd_t       cmd_d;
  logic [1:0] frag_q, frag_d;
  logic [1:0] timer_q, timer_d;
  logic [2:0] armed_q, armed_d;
  logic       pump_on_q, pump_off_q, manual_on_q;

  // Arbitrate commands (stop > start > manual); select presses only land on idle cycles.
  always_comb begin
    cmd_d   = CMD_NONE;
    frag_d  = frag_q;
    timer_d = timer_q;
    armed_d = armed_q;
    if (stop_press)                   cmd_d = CMD_OFF;
    else if (start_on)                cmd_d = CMD_ON;
    else if (manual_press | start_man) cmd_d = CMD_MANUAL;

    if (cmd_d == CMD_NONE) begin
      if (frag_press)  frag_d  = (frag_q == FRAG_LAST) ? 2'd0 : frag_q + 2'd1;
      if (timer_press) timer_d = (timer_q == TMR_120M) ? TMR_30M : timer_q + 2'd1;
    end

    case (cmd_d)
      CMD_ON:  armed_d = armed_q | (3'b001 << frag_q);
      CMD_OFF: armed_d = '0;
      default: armed_d = armed_q;
    endcase
  end

  // Registered outputs to the pump controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frag_q      <= '0;
      timer_q     <= TMR_30M;
      armed_q     <= '0;
      pump_on_q   <= 1'b0;
      pump_off_q  <= 1'b0;
      manual_on_q <= 1'b0;
    end else begin
      frag_q      <= frag_d;
      timer_q     <= timer_d;
      armed_q     <= armed_d;
      pump_on_q   <= (cmd_d == CMD_ON);
      pump_off_q  <= (cmd_d == CMD_OFF);
      manual_on_q <= (cmd_d == CMD_MANUAL);
    end
  end

  assign bus.fragrance_select = frag_q;
  assign bus.timer_select     = timer_q;
  assign bus.armed_mask       = armed_q;
  assign bus.pump_on          = pump_on_q;
  assign bus.pump_off         = pump_off_q;
  assign bus.manual_on        = manual_on_q;

endmodule
